param_counter: RTL and testbench
================================

# param_counter

Parametrised up/down counter, successor to the fixed 32-bit free-running `counter`. Adds configurable width and terminal value, wrap or saturate mode, synchronous clear/load, count enable with an integer prescaler, and terminal-count flags. Used as a general timing/event counter in the `rtl_core` library. Also used wherever a bench or block needs a programmable period or timeout.

## Interface
Parameters:
- `WIDTH`, 32: counter width in bits, 2..32.
- `MAX_VAL`, 2**WIDTH-1: terminal (highest) count value, 1..2**WIDTH-1.
- `SATURATE`, 0: 0 = wrap at the bounds, 1 = hold at the bounds.
- `PRESCALE`, 1: number of enabled cycles per count step, 1..65536.

Ports:
- `clk`  in  1  rising-edge clock; only clock of the block.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `clr`  in  1  synchronous clear of count and prescaler.
- `load`  in  1  synchronous load of `load_val`, also clears the prescaler.
- `load_val`  in  WIDTH  value to load.
- `en`  in  1  count enable; advances the prescaler.
- `dir`  in  1  1 = count up, 0 = count down.
- `count`  out  WIDTH  registered counter value.
- `tc`  out  1  registered one-cycle pulse on a wrap or saturation step.
- `at_max`  out  1  combinational, `count == MAX_VAL`.
- `at_zero`  out  1  combinational, `count == 0`.

## Operation
- Priority per cycle: `clr` > `load` > step > hold.
- `clr`: count <- 0, prescaler <- 0, tc <- 0.
- `load`: count <- min(`load_val`, MAX_VAL), prescaler <- 0, tc <- 0.
- Prescaler counts enabled cycles 0..PRESCALE-1.
  - A step fires on an enabled cycle where the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - With PRESCALE=1, every enabled cycle is a step.
  - `en`=0 freezes the prescaler and the count.
- Up step:
  - count < MAX_VAL: count+1, tc <- 0.
  - count = MAX_VAL: wrap mode gives 0 with tc <- 1; saturate mode holds MAX_VAL with tc <- 1.
- Down step:
  - count > 0: count-1, tc <- 0.
  - count = 0: wrap mode gives MAX_VAL with tc <- 1; saturate mode holds 0 with tc <- 1.
- In saturate mode, each further step at a bound re-pulses `tc`.
- Non-step cycles drive tc <- 0.
- `dir` is sampled only on step cycles; changing `dir` never touches the prescaler.
- Arithmetic is WIDTH bits, with no wrap through 2**WIDTH unless MAX_VAL = 2**WIDTH-1.
- Count values above MAX_VAL are unreachable, because `load` clamps.

## Timing
- Reset asserted (`reset`=0): count=0, prescaler=0, tc=0 immediately, without waiting for a clock. `at_zero`=1 and `at_max`=0.
- Deassertion of `reset` is synchronised externally; the first update follows the first rising edge after release.
- Latency: `count` and `tc` change one edge after the step, clr or load condition is sampled. `at_max` and `at_zero` follow `count` in the same cycle.
- `tc` is high for exactly one cycle per wrap or saturation step.
- Reset mid-prescale discards the partial prescale. After release, the first step needs a full PRESCALE enabled cycles.
- `clr` and `load` in the same cycle: `clr` wins.
- `load` on a step cycle: load wins and no step occurs.

## Structure
- Shared include `counter_defs.vh`: `DIR_UP`=1, `DIR_DOWN`=0, `MODE_WRAP`=0, `MODE_SAT`=1.
- Sub-module `tick_gen`: the prescaler, a clog2(PRESCALE)-bit counter.
  - Inputs: `clk`, `reset`, `clr` (driven by clr|load), `en`.
  - Output: `tick`, one-cycle step strobe.
  - With PRESCALE=1, `tick` = `en`.
- `param_counter` holds the count register, the bound compare, the mode mux and `tc`.
- Parameter legality is checked at elaboration; an illegal value stops simulation with `$error`.

## Test plan
- Reset and count: WIDTH=32, defaults, `en`=1, `dir`=1, release reset at 20 ns, 25 ns clock -> count is 0 during reset, then 1, 2, … and reaches 11 on the 11th edge after release. No `tc`.
- Wrap: WIDTH=4, MAX_VAL=9, SATURATE=0, up -> sequence 8, 9, 0 with `tc`=1 only in the cycle count=0. Down from 0 -> 9 with `tc`=1.
- Saturate: MAX_VAL=9, SATURATE=1, up from 8 for 3 steps -> 9, 9, 9 with `tc` high in the 2nd and 3rd cycles. `at_max`=1 throughout.
- Prescale: PRESCALE=4, `en` toggling 1,1,0,1,1 -> count increments once, on the 4th enabled cycle. Asserting `reset` after 2 enabled cycles requires 4 fresh enabled cycles after release.
- Load and clear priority:
  - `load_val`=15 with MAX_VAL=9 -> count=9.
  - `clr` and `load` together -> count=0.
  - `load`=5 on a step cycle -> count=5, not 6, and `tc`=0.
- Async reset mid-run: assert `reset` between clock edges while count=7 -> count=0 and `tc`=0 immediately, before the next edge.

Source files
------------

// File: rtl/param_counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
`timescale 1ns / 100ps
package param_counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Width of the prescaler counter; at least one bit so PRESCALE=1 needs no special case.
  function automatic int unsigned prescale_width(input int unsigned prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/param_counter_tick_gen.sv
// Prescaler: emits a one-cycle step strobe every PRESCALE enabled cycles.
`timescale 1ns / 100ps
module param_counter_tick_gen
  import param_counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = prescale_width(PRESCALE);
  localparam logic [CntW-1:0] LastCnt = CntW'(PRESCALE - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // With PRESCALE=1 the counter is pinned at 0, so tick reduces to en.
  assign tick = en && (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/param_counter.sv
// Parametrised up/down counter with wrap/saturate bounds, clear/load,
// prescaled enable and a terminal-count pulse.
`timescale 1ns / 100ps
module param_counter
  import param_counter_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter int unsigned      SATURATE = 0,
  parameter int unsigned      PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_max,
  output logic             at_zero
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("param_counter: WIDTH must be 2..32");
  end
  if (MAX_VAL == '0) begin : g_bad_max
    $error("param_counter: MAX_VAL must be at least 1");
  end
  if (SATURATE > 1) begin : g_bad_mode
    $error("param_counter: SATURATE must be 0 or 1");
  end
  if (PRESCALE < 1 || PRESCALE > 65536) begin : g_bad_prescale
    $error("param_counter: PRESCALE must be 1..65536");
  end

  localparam logic Mode = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

  logic [WIDTH-1:0] count_q, count_d, load_clamped;
  logic             tc_q, tc_d;
  logic             tick;

  param_counter_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clr  (clr | load),
    .en   (en),
    .tick (tick)
  );

  assign at_max       = (count_q == MAX_VAL);
  assign at_zero      = (count_q == '0);
  assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_clamped;
    end else if (tick) begin
      unique case (dir)
        DIR_UP: begin
          if (at_max) begin
            tc_d    = 1'b1;
            count_d = (Mode == MODE_SAT) ? MAX_VAL : '0;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
        DIR_DOWN: begin
          if (at_zero) begin
            tc_d    = 1'b1;
            count_d = (Mode == MODE_SAT) ? '0 : MAX_VAL;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;

endmodule

// File: tb/tb_param_counter.sv
// Bench: four counter configurations driven in parallel, checked every cycle
// against an arithmetic model plus directed literal expectations.
`timescale 1ns / 100ps
module tb_param_counter;

  localparam int NI = 4;
  // Configurations: 32-bit default, 4-bit MAX 9 wrap, 4-bit MAX 9 saturate, 8-bit prescale 4.
  localparam longint P_MAX [NI] = '{64'hFFFF_FFFF, 9, 9, 255};
  localparam int     P_W   [NI] = '{32, 4, 4, 8};
  localparam bit     P_SAT [NI] = '{1'b0, 1'b0, 1'b1, 1'b0};
  localparam longint P_PRE [NI] = '{1, 1, 1, 4};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clr = 1'b0, load = 1'b0, en = 1'b1, dir = 1'b1;
  logic [31:0] load_val = '0;

  logic [31:0]   cnt0;
  logic [3:0]    cnt1, cnt2;
  logic [7:0]    cnt3;
  logic [NI-1:0] tc_v, max_v, zero_v;

  int n_checks = 0;
  int n_fail = 0;

  always #12.5 clk = ~clk;

  param_counter #(.WIDTH(32)) u_dut0 (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val), .en(en), .dir(dir),
    .count(cnt0), .tc(tc_v[0]), .at_max(max_v[0]), .at_zero(zero_v[0])
  );
  param_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(0)) u_dut1 (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val[3:0]), .en(en),
    .dir(dir), .count(cnt1), .tc(tc_v[1]), .at_max(max_v[1]), .at_zero(zero_v[1])
  );
  param_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1)) u_dut2 (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val[3:0]), .en(en),
    .dir(dir), .count(cnt2), .tc(tc_v[2]), .at_max(max_v[2]), .at_zero(zero_v[2])
  );
  param_counter #(.WIDTH(8), .PRESCALE(4)) u_dut3 (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val[7:0]), .en(en),
    .dir(dir), .count(cnt3), .tc(tc_v[3]), .at_max(max_v[3]), .at_zero(zero_v[3])
  );

  function automatic longint get_cnt(input int i);
    case (i)
      0:       return longint'(cnt0);
      1:       return longint'(cnt1);
      2:       return longint'(cnt2);
      default: return longint'(cnt3);
    endcase
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integer arithmetic over the counter rules.
  longint m_cnt [NI];
  longint m_pre [NI];
  bit     m_tc  [NI];
  longint nc, np;
  bit     nt;

  function automatic void model_step(input int i, output longint c, output longint p,
                                     output bit t);
    longint lv;
    lv = longint'(load_val) & ((longint'(1) << P_W[i]) - 1);
    c = m_cnt[i];
    p = m_pre[i];
    t = 1'b0;
    if (clr) begin
      c = 0;
      p = 0;
    end else if (load) begin
      c = (lv > P_MAX[i]) ? P_MAX[i] : lv;
      p = 0;
    end else if (en) begin
      if (p + 1 < P_PRE[i]) begin
        p = p + 1;
      end else begin
        p = 0;
        if (dir) begin
          t = (c == P_MAX[i]);
          c = (c < P_MAX[i]) ? c + 1 : (P_SAT[i] ? c : 0);
        end else begin
          t = (c == 0);
          c = (c > 0) ? c - 1 : (P_SAT[i] ? c : P_MAX[i]);
        end
      end
    end
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NI; i++) begin
        m_cnt[i] <= 0;
        m_pre[i] <= 0;
        m_tc[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        model_step(i, nc, np, nt);
        m_cnt[i] <= nc;
        m_pre[i] <= np;
        m_tc[i]  <= nt;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("model_count%0d", i), get_cnt(i), m_cnt[i]);
      chk($sformatf("model_tc%0d", i), longint'(tc_v[i]), longint'(m_tc[i]));
      chk($sformatf("model_at_max%0d", i), longint'(max_v[i]), longint'(m_cnt[i] == P_MAX[i]));
      chk($sformatf("model_at_zero%0d", i), longint'(zero_v[i]), longint'(m_cnt[i] == 0));
    end
  end

  task automatic drive(input bit c, input bit l, input logic [31:0] lv, input bit e,
                       input bit d);
    clr = c; load = l; load_val = lv; en = e; dir = d;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset and free count
    #5;
    chk("rst_count", longint'(cnt0), 0);
    chk("rst_at_zero", longint'(zero_v[0]), 1);
    chk("rst_at_max", longint'(max_v[0]), 0);
    chk("rst_tc", longint'(tc_v[0]), 0);
    #15 reset = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    #1;
    chk("count_11th_edge", longint'(cnt0), 11);
    chk("count_no_tc", longint'(tc_v[0]), 0);

    // Wrap (dut1) and saturate (dut2) from 8 upward
    drive(0, 1, 8, 1, 1);
    chk("load8_wrap", longint'(cnt1), 8);
    drive(0, 0, 0, 1, 1);
    chk("wrap_9", longint'(cnt1), 9);
    chk("wrap_9_tc", longint'(tc_v[1]), 0);
    chk("sat_9", longint'(cnt2), 9);
    chk("sat_9_tc", longint'(tc_v[2]), 0);
    chk("sat_9_at_max", longint'(max_v[2]), 1);
    drive(0, 0, 0, 1, 1);
    chk("wrap_0", longint'(cnt1), 0);
    chk("wrap_0_tc", longint'(tc_v[1]), 1);
    chk("sat_hold1", longint'(cnt2), 9);
    chk("sat_hold1_tc", longint'(tc_v[2]), 1);
    drive(0, 0, 0, 1, 1);
    chk("wrap_1_tc", longint'(tc_v[1]), 0);
    chk("sat_hold2", longint'(cnt2), 9);
    chk("sat_hold2_tc", longint'(tc_v[2]), 1);
    chk("sat_hold2_at_max", longint'(max_v[2]), 1);
    drive(1, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 0);
    chk("down_wrap_9", longint'(cnt1), 9);
    chk("down_wrap_tc", longint'(tc_v[1]), 1);
    chk("down_sat_0", longint'(cnt2), 0);
    chk("down_sat_tc", longint'(tc_v[2]), 1);

    // Prescale 4 with en 1,1,0,1,1
    drive(1, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 1);
    chk("pre_3rd_en", longint'(cnt3), 0);
    drive(0, 0, 0, 1, 1);
    chk("pre_4th_en", longint'(cnt3), 1);
    // Two enabled cycles, then reset discards the partial prescale
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 1);
    reset = 1'b0;
    #1;
    chk("pre_rst_count", longint'(cnt3), 0);
    #2 reset = 1'b1;
    repeat (3) drive(0, 0, 0, 1, 1);
    chk("pre_after_rst_3", longint'(cnt3), 0);
    drive(0, 0, 0, 1, 1);
    chk("pre_after_rst_4", longint'(cnt3), 1);

    // Load clamp and priority
    drive(0, 1, 15, 0, 1);
    chk("load_clamp", longint'(cnt1), 9);
    chk("load_noclamp", longint'(cnt3), 15);
    drive(1, 1, 5, 1, 1);
    chk("clr_beats_load", longint'(cnt1), 0);
    drive(0, 1, 9, 0, 1);
    drive(0, 1, 5, 1, 1);
    chk("load_beats_step", longint'(cnt1), 5);
    chk("load_beats_step_tc", longint'(tc_v[1]), 0);

    // Async reset clears a pending tc without a clock edge
    drive(0, 1, 1, 0, 1);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    chk("pre_async_tc", longint'(tc_v[1]), 1);
    reset = 1'b0;
    #1;
    chk("async_count", longint'(cnt1), 0);
    chk("async_tc1", longint'(tc_v[1]), 0);
    chk("async_tc2", longint'(tc_v[2]), 0);
    chk("async_at_zero", longint'(zero_v[1]), 1);
    #2 reset = 1'b1;

    // Async reset with count=7
    drive(0, 1, 8, 0, 1);
    drive(0, 0, 0, 1, 0);
    chk("count7", longint'(cnt1), 7);
    reset = 1'b0;
    #1;
    chk("async7_count", longint'(cnt1), 0);
    #2 reset = 1'b1;
    drive(0, 0, 0, 1, 1);
    chk("after_async7", longint'(cnt1), 1);
    drive(0, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
